// File: rtl/axil_rr_arbiter_if.sv
// Manager-side and subordinate-side AXI4-Lite bundles for axil_rr_arbiter.
// axil_mgr_if carries N_M packed manager ports; axil_sub_if is the single shared subordinate.
interface axil_mgr_if #(
  parameter int N_M    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic [N_M-1:0]        m_awvalid, m_awready;
  logic [N_M*ADDR_W-1:0] m_awaddr;
  logic [N_M-1:0]        m_wvalid, m_wready;
  logic [N_M*DATA_W-1:0] m_wdata;
  logic [N_M*STRB_W-1:0] m_wstrb;
  logic [N_M-1:0]        m_bvalid, m_bready;
  logic [1:0]            m_bresp;
  logic [N_M-1:0]        m_arvalid, m_arready;
  logic [N_M*ADDR_W-1:0] m_araddr;
  logic [N_M-1:0]        m_rvalid, m_rready;
  logic [DATA_W-1:0]     m_rdata;
  logic [1:0]            m_rresp;

  modport master (
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
  );
  modport slave (
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
  );
endinterface

interface axil_sub_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              s_awvalid, s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid, s_wready;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_bvalid, s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid, s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_rvalid, s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
  );
  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/axil_rr_arbiter.sv
// N_M-manager to one-subordinate AXI4-Lite arbiter; write and read paths locked per transaction.
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module axil_rr_arbiter #(
  parameter int N_M    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  axil_mgr_if.slave      mgr,
  axil_sub_if.master     sub,
  output logic [N_M-1:0] wr_gnt,
  output logic [N_M-1:0] rd_gnt
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_M);
  localparam logic [N_M-1:0] ONE = {{(N_M-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_e;

  wr_state_e        wr_state_q;
  rd_state_e        rd_state_q;
  logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
  logic [N_M-1:0]   wr_gnt_q, rd_gnt_q;
  logic [IDX_W-1:0] wr_start, rd_start;
  logic [IDX_W-1:0] wr_win_d, rd_win_d;
  logic             wr_b_hs, rd_r_hs;

  // First requester found scanning upward from start, wrapping at N_M.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_M-1:0] req,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_M; k++) begin
      idx = int'(start) + k;
      if (idx >= N_M) idx = idx - N_M;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign wr_win_d = rr_pick(mgr.m_awvalid, wr_start);
  assign rd_win_d = rr_pick(mgr.m_arvalid, rd_start);
  assign wr_b_hs  = (wr_state_q == W_RESP) && sub.s_bvalid && mgr.m_bready[wr_idx_q];
  assign rd_r_hs  = (rd_state_q == R_RESP) && sub.s_rvalid && mgr.m_rready[rd_idx_q];

`ifdef ARB_FIXED_PRIO_EN
  assign wr_start = '0;
  assign rd_start = '0;
`else
  logic [IDX_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0] wr_ptr_d, rd_ptr_d;

  assign wr_ptr_d = (int'(wr_idx_q) == N_M - 1) ? '0 : wr_idx_q + 1'b1;
  assign rd_ptr_d = (int'(rd_idx_q) == N_M - 1) ? '0 : rd_idx_q + 1'b1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_b_hs) wr_ptr_q <= wr_ptr_d;
      if (rd_r_hs) rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_start = wr_ptr_q;
  assign rd_start = rd_ptr_q;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state_q <= W_IDLE;
      wr_idx_q   <= '0;
      wr_gnt_q   <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (|mgr.m_awvalid) begin
          wr_idx_q   <= wr_win_d;
          wr_gnt_q   <= ONE << wr_win_d;
          wr_state_q <= W_ADDR;
        end
        W_ADDR: if (sub.s_awvalid && sub.s_awready) wr_state_q <= W_DATA;
        W_DATA: if (sub.s_wvalid && sub.s_wready) wr_state_q <= W_RESP;
        W_RESP: if (wr_b_hs) begin
          wr_gnt_q   <= '0;
          wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_q <= R_IDLE;
      rd_idx_q   <= '0;
      rd_gnt_q   <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (|mgr.m_arvalid) begin
          rd_idx_q   <= rd_win_d;
          rd_gnt_q   <= ONE << rd_win_d;
          rd_state_q <= R_ADDR;
        end
        R_ADDR: if (sub.s_arvalid && sub.s_arready) rd_state_q <= R_RESP;
        R_RESP: if (rd_r_hs) begin
          rd_gnt_q   <= '0;
          rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Payloads follow the granted index; only valid/ready are gated by phase.
  always_comb begin
    sub.s_awvalid = 1'b0;
    sub.s_awaddr  = mgr.m_awaddr[int'(wr_idx_q)*ADDR_W +: ADDR_W];
    sub.s_wvalid  = 1'b0;
    sub.s_wdata   = mgr.m_wdata[int'(wr_idx_q)*DATA_W +: DATA_W];
    sub.s_wstrb   = mgr.m_wstrb[int'(wr_idx_q)*STRB_W +: STRB_W];
    sub.s_bready  = 1'b0;
    mgr.m_awready = '0;
    mgr.m_wready  = '0;
    mgr.m_bvalid  = '0;
    case (wr_state_q)
      W_ADDR: begin
        sub.s_awvalid           = mgr.m_awvalid[wr_idx_q];
        mgr.m_awready[wr_idx_q] = sub.s_awready;
      end
      W_DATA: begin
        sub.s_wvalid           = mgr.m_wvalid[wr_idx_q];
        mgr.m_wready[wr_idx_q] = sub.s_wready;
      end
      W_RESP: begin
        mgr.m_bvalid[wr_idx_q] = sub.s_bvalid;
        sub.s_bready           = mgr.m_bready[wr_idx_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    sub.s_arvalid = 1'b0;
    sub.s_araddr  = mgr.m_araddr[int'(rd_idx_q)*ADDR_W +: ADDR_W];
    sub.s_rready  = 1'b0;
    mgr.m_arready = '0;
    mgr.m_rvalid  = '0;
    case (rd_state_q)
      R_ADDR: begin
        sub.s_arvalid           = mgr.m_arvalid[rd_idx_q];
        mgr.m_arready[rd_idx_q] = sub.s_arready;
      end
      R_RESP: begin
        mgr.m_rvalid[rd_idx_q] = sub.s_rvalid;
        sub.s_rready           = mgr.m_rready[rd_idx_q];
      end
      default: ;
    endcase
  end

  assign mgr.m_bresp = sub.s_bresp;
  assign mgr.m_rdata = sub.s_rdata;
  assign mgr.m_rresp = sub.s_rresp;
  assign wr_gnt      = wr_gnt_q;
  assign rd_gnt      = rd_gnt_q;

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench for axil_rr_arbiter with a 4 KiB behavioural subordinate.
// Expectations switch to fixed priority when ARB_FIXED_PRIO_EN is defined.
module tb_axil_rr_arbiter;
  localparam int N_M    = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam logic [63:0] INIT20 = 64'hA0A0_A0A0_A0A0_A0A0;
  localparam logic [63:0] INIT28 = 64'hB0B0_B0B0_B0B0_B0B0;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axil_mgr_if #(.N_M(N_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();
  axil_sub_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();
  logic [N_M-1:0] wr_gnt, rd_gnt;

  axil_rr_arbiter #(.N_M(N_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .mgr(mif), .sub(sif),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
  );

  // ---------------- subordinate model ----------------
  logic [63:0]  mem [512];
  logic [511:0] written_q;
  logic         pre_q = 1'b0;
  logic [31:0]  aw_addr_q;

  function automatic logic [63:0] rd_word(input logic [31:0] a);
    int i;
    i = int'(a[11:3]);
    if (written_q[i]) return mem[i];
    if (i == 4) return INIT20;
    if (i == 5) return INIT28;
    return 64'h0;
  endfunction

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  assign sif.s_awready = 1'b1;
  assign sif.s_wready  = !sif.s_bvalid;
  assign sif.s_arready = !sif.s_rvalid;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sif.s_bvalid <= 1'b0; sif.s_bresp <= 2'b00;
      sif.s_rvalid <= 1'b0; sif.s_rdata <= '0; sif.s_rresp <= 2'b00;
      aw_addr_q    <= '0;
      if (!pre_q) begin written_q <= '0; pre_q <= 1'b1; end
    end else begin
      if (sif.s_awvalid && sif.s_awready) aw_addr_q <= sif.s_awaddr;
      if (sif.s_wvalid && sif.s_wready) begin
        if (aw_addr_q < 32'h1000) begin
          mem[aw_addr_q[11:3]] <= (rd_word(aw_addr_q) & ~strb_mask(sif.s_wstrb)) |
                                  (sif.s_wdata & strb_mask(sif.s_wstrb));
          written_q[aw_addr_q[11:3]] <= 1'b1;
          sif.s_bresp <= 2'b00;
        end else sif.s_bresp <= 2'b10;
        sif.s_bvalid <= 1'b1;
      end else if (sif.s_bvalid && sif.s_bready) sif.s_bvalid <= 1'b0;
      if (sif.s_arvalid && sif.s_arready) begin
        sif.s_rvalid <= 1'b1;
        sif.s_rdata  <= (sif.s_araddr < 32'h1000) ? rd_word(sif.s_araddr) : 64'h0;
        sif.s_rresp  <= (sif.s_araddr < 32'h1000) ? 2'b00 : 2'b10;
      end else if (sif.s_rvalid && sif.s_rready) sif.s_rvalid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({wr_gnt, rd_gnt, mif.m_awready, mif.m_wready, mif.m_bvalid,
                mif.m_arready, mif.m_rvalid, sif.s_awvalid, sif.s_wvalid,
                sif.s_bready, sif.s_arvalid, sif.s_rready});
  endfunction

  logic [N_M-1:0] wg [8];
  logic [N_M-1:0] rg [8];
  logic [1:0]     bresp_l [8];
  logic [63:0]    rdata_l [8];
  logic [1:0]     rresp_l [8];
  int             nwg, nrg, nb, nr;
  bit             both_act, b1_seen;

  // Watches both paths until want_b B and want_r R handshakes; drops a path's
  // valids/readies at the negedge after its last wanted handshake.
  task automatic run(input int want_b, input int want_r, input int max_cyc);
    logic [N_M-1:0] pw, pr;
    bit drop_w, drop_r;
    nwg = 0; nrg = 0; nb = 0; nr = 0; both_act = 0; b1_seen = 0;
    pw = '0; pr = '0; drop_w = 0; drop_r = 0;
    for (int c = 0; c < max_cyc && (nb < want_b || nr < want_r); c++) begin
      @(negedge ACLK);
      if (drop_w) begin mif.m_awvalid = '0; mif.m_wvalid = '0; mif.m_bready = '0; drop_w = 0; end
      if (drop_r) begin mif.m_arvalid = '0; mif.m_rready = '0; drop_r = 0; end
      if (wr_gnt != '0 && pw == '0 && nwg < 8) begin wg[nwg] = wr_gnt; nwg++; end
      if (rd_gnt != '0 && pr == '0 && nrg < 8) begin rg[nrg] = rd_gnt; nrg++; end
      pw = wr_gnt; pr = rd_gnt;
      if (wr_gnt != '0 && rd_gnt != '0) both_act = 1;
      if (mif.m_bvalid[1]) b1_seen = 1;
      for (int i = 0; i < N_M; i++) begin
        if (mif.m_bvalid[i] && mif.m_bready[i] && nb < 8) begin
          bresp_l[nb] = mif.m_bresp; nb++;
          if (nb == want_b) drop_w = 1;
        end
        if (mif.m_rvalid[i] && mif.m_rready[i] && nr < 8) begin
          rdata_l[nr] = mif.m_rdata; rresp_l[nr] = mif.m_rresp; nr++;
          if (nr == want_r) drop_r = 1;
        end
      end
    end
    @(negedge ACLK);
    if (drop_w) begin mif.m_awvalid = '0; mif.m_wvalid = '0; mif.m_bready = '0; end
    if (drop_r) begin mif.m_arvalid = '0; mif.m_rready = '0; end
  endtask

  bit seen;

  initial begin
    mif.m_awvalid = '0; mif.m_awaddr = '0; mif.m_wvalid = '0; mif.m_wdata = '0;
    mif.m_wstrb = '0; mif.m_bready = '0; mif.m_arvalid = '0; mif.m_araddr = '0;
    mif.m_rready = '0;

    repeat (3) @(negedge ACLK);
    chk("rst_outputs", outs(), 64'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("idle_outputs", outs(), 64'h0);

    // T1: both managers write at once
    mif.m_awaddr = {32'h18, 32'h10};
    mif.m_wdata  = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    mif.m_wstrb  = '1;
    mif.m_awvalid = 2'b11; mif.m_wvalid = 2'b11; mif.m_bready = 2'b11;
    run(2, 0, 60);
    chk("t1_done", 64'(nb), 64'd2);
    chk("t1_gnt0", 64'(wg[0]), 64'b01);
`ifdef ARB_FIXED_PRIO_EN
    chk("t1_gnt1", 64'(wg[1]), 64'b01);
    chk("t1_mem18", rd_word(32'h18), 64'h0);
`else
    chk("t1_gnt1", 64'(wg[1]), 64'b10);
    chk("t1_mem18", rd_word(32'h18), 64'h2222_2222_2222_2222);
`endif
    chk("t1_bresp0", 64'(bresp_l[0]), 64'd0);
    chk("t1_bresp1", 64'(bresp_l[1]), 64'd0);
    chk("t1_mem10", rd_word(32'h10), 64'h1111_1111_1111_1111);

    // T2: continuous reads, m0 at 0x28, m1 at 0x20
    mif.m_araddr = {32'h20, 32'h28};
    mif.m_arvalid = 2'b11; mif.m_rready = 2'b11;
    run(0, 3, 60);
    chk("t2_done", 64'(nr), 64'd3);
    chk("t2_gnt0", 64'(rg[0]), 64'b01);
    chk("t2_rdata0", rdata_l[0], INIT28);
`ifdef ARB_FIXED_PRIO_EN
    chk("t2_gnt1", 64'(rg[1]), 64'b01);
    chk("t2_rdata1", rdata_l[1], INIT28);
`else
    chk("t2_gnt1", 64'(rg[1]), 64'b10);
    chk("t2_rdata1", rdata_l[1], INIT20);
    chk("t2_alternate", 64'((rg[0] != rg[1]) && (rg[1] != rg[2])), 64'd1);
`endif
    chk("t2_gnt2", 64'(rg[2]), 64'b01);
    chk("t2_rdata2", rdata_l[2], INIT28);
    chk("t2_rresp", 64'(rresp_l[0] | rresp_l[1] | rresp_l[2]), 64'd0);

    // T3: out-of-range write from m0
    mif.m_awaddr = {32'h0, 32'h1000};
    mif.m_awvalid = 2'b01; mif.m_wvalid = 2'b01; mif.m_bready = 2'b01;
    run(1, 0, 40);
    chk("t3_done", 64'(nb), 64'd1);
    chk("t3_bresp", 64'(bresp_l[0]), 64'b10);
    chk("t3_m1_bvalid", 64'(b1_seen), 64'd0);

    // T4: m0 writes 0x40 while m1 reads 0x40
    mif.m_awaddr = {32'h0, 32'h40};
    mif.m_wdata  = {64'h0, 64'h4444_4444_4444_4444};
    mif.m_araddr = {32'h40, 32'h0};
    mif.m_awvalid = 2'b01; mif.m_wvalid = 2'b01; mif.m_bready = 2'b01;
    mif.m_arvalid = 2'b10; mif.m_rready = 2'b10;
    run(1, 1, 40);
    chk("t4_done", 64'(nb + nr), 64'd2);
    chk("t4_both_active", 64'(both_act), 64'd1);
    chk("t4_rgnt", 64'(rg[0]), 64'b10);
    chk("t4_rdata_old_or_new",
        64'((rdata_l[0] == 64'h0) || (rdata_l[0] == 64'h4444_4444_4444_4444)), 64'd1);
    chk("t4_rresp", 64'(rresp_l[0]), 64'd0);
    chk("t4_bresp", 64'(bresp_l[0]), 64'd0);
    chk("t4_mem40", rd_word(32'h40), 64'h4444_4444_4444_4444);

    // T5: reset pulsed during W_DATA, then a clean m1 write
    mif.m_awaddr = {32'h30, 32'h48};
    mif.m_wdata  = {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    mif.m_awvalid = 2'b01; mif.m_wvalid = 2'b01; mif.m_bready = 2'b01;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge ACLK);
      if (sif.s_wvalid) seen = 1;
    end
    chk("t5_wdata_phase", 64'(seen), 64'd1);
    ARESETn = 1'b0;
    #1;
    chk("t5_rst_outputs", outs(), 64'h0);
    @(negedge ACLK);
    chk("t5_rst_next_cycle", outs(), 64'h0);
    mif.m_awvalid = '0; mif.m_wvalid = '0; mif.m_bready = '0;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("t5_mem48_untouched", rd_word(32'h48), 64'h0);
    mif.m_awvalid = 2'b10; mif.m_wvalid = 2'b10; mif.m_bready = 2'b10;
    run(1, 0, 40);
    chk("t5_done", 64'(nb), 64'd1);
    chk("t5_gnt", 64'(wg[0]), 64'b10);
    chk("t5_bresp", 64'(bresp_l[0]), 64'd0);
    chk("t5_mem30", rd_word(32'h30), 64'h6666_6666_6666_6666);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_rr_arbiter.md
Name: axil_rr_arbiter

Overview:
- Shares one 64-bit AXI4-Lite subordinate (4 KiB byte memory, OKAY/SLVERR responses) between N_M managers.
- Write path (AW/W/B) and read path (AR/R) are arbitrated independently.
- Each path locks to one manager from grant until its response handshake completes.
- Round-robin by default; fixed priority is a compile option.

Parameters:
- N_M, 2, number of managers (2..8).
- ADDR_W, 32, address width.
- DATA_W, 64, data width; STRB_W = DATA_W/8.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- m_awvalid, m_awready  in/out  N_M  per-manager AW handshake.
- m_awaddr  in  N_M*ADDR_W  packed; manager i at [i*ADDR_W +: ADDR_W].
- m_wvalid, m_wready  in/out  N_M  per-manager W handshake.
- m_wdata, m_wstrb  in  N_M*DATA_W, N_M*STRB_W  packed write data and strobes.
- m_bvalid, m_bready  out/in  N_M  per-manager B handshake.
- m_bresp  out  2  B response, shared; valid only where m_bvalid is set.
- m_arvalid, m_arready  in/out  N_M  per-manager AR handshake.
- m_araddr  in  N_M*ADDR_W  packed read addresses.
- m_rvalid, m_rready  out/in  N_M  per-manager R handshake.
- m_rdata, m_rresp  out  DATA_W, 2  shared read data and response.
- s_awvalid, s_awready, s_awaddr  out/in/out  1,1,ADDR_W  subordinate AW.
- s_wvalid, s_wready, s_wdata, s_wstrb  out/in/out/out  1,1,DATA_W,STRB_W  subordinate W.
- s_bvalid, s_bready, s_bresp  in/out/in  1,1,2  subordinate B.
- s_arvalid, s_arready, s_araddr  out/in/out  1,1,ADDR_W  subordinate AR.
- s_rvalid, s_rready, s_rdata, s_rresp  in/out/in/in  1,1,DATA_W,2  subordinate R.
- wr_gnt, rd_gnt  out  N_M  one-hot registered grants (debug/monitor).

Behaviour:
- Reset: both FSMs IDLE; wr_ptr = rd_ptr = 0; wr_gnt = rd_gnt = 0. All valid/ready outputs toward managers and subordinate are 0; s_bready = s_rready = 0.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: if any m_awvalid, pick winner by round-robin from wr_ptr and register wr_gnt. Go to W_ADDR next cycle, giving 1-cycle arbitration latency.
  - W_ADDR: s_aw* = winner's AW; m_awready[g] = s_awready. On handshake go to W_DATA.
  - W_DATA: s_w* = winner's W; m_wready[g] = s_wready. On handshake go to W_RESP.
  - W_RESP: m_bvalid[g] = s_bvalid; s_bready = m_bready[g]; m_bresp = s_bresp. On handshake: wr_ptr = g+1 mod N_M, wr_gnt = 0, go to W_IDLE.
- Write data presented before AW completes is not forwarded; W strictly follows AW.
- Read FSM states: R_IDLE, R_ADDR, R_RESP.
  - Arbitration and grant register work as on the write side, using rd_ptr.
  - R_ADDR forwards AR.
  - R_RESP forwards R; rd_ptr advances on the R handshake.
- Non-granted managers always see ready = 0 and valid = 0.
- Request withdrawal (AXI violation) is not checked: the grant holds until completion.
- Read and write may be in flight simultaneously, to the same or different managers.
- Responses (including SLVERR) pass through unmodified.
- A single requester is re-granted back-to-back, with one IDLE cycle between transactions.
- ARESETn asserted mid-transaction aborts it: FSMs return to IDLE and pointers return to 0 asynchronously; no response is delivered.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: lowest-index requesting manager always wins; wr_ptr and rd_ptr are not implemented.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- m0 and m1 both raise awvalid at cycle 0, addr 0x10 / 0x18, wdata 0x11.. / 0x22.. -> m0 granted first with wr_gnt = 01; m1 granted after m0's B handshake with wr_gnt = 10; memory holds both values; each BRESP = 00.
- m1 issues continuous reads of 0x20 while m0 reads 0x28 -> grants alternate m0, m1, m0; rd_gnt never stays on one manager for 2 consecutive grants while both request.
- m0 writes 0x1000 (out of range) -> m0 sees bvalid with bresp = 10; m1 sees m_bvalid[1] = 0 throughout.
- m0 write to 0x40 concurrent with m1 read of 0x40 -> both paths are active in the same cycle; the read returns the old or new value depending on subordinate ordering, with RRESP = 00.
- ARESETn pulsed low during W_DATA -> next cycle all valid/ready outputs are 0 and wr_gnt = 0; a subsequent m1 write completes normally.
- With ARB_FIXED_PRIO_EN, m0 and m1 requesting continuously -> m0 wins every grant.
